// File: rtl/output_pixel_writer.sv
// Packs PE result beats into full-depth pixel words and writes them to the next layer's FIFO,
// tracking the output raster and pulsing o_frame_done. Optional macro: OUTPUT_RELU_EN clamps negative channels to zero.
module output_pixel_writer #(
    parameter int DATA_WIDTH  = 8,
    parameter int OUT_CHANNEL = 16,
    parameter int PE_CHANNELS = 4,
    parameter int OUT_WIDTH   = 32,
    parameter int OUT_HEIGHT  = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH*PE_CHANNELS-1:0] i_data,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic                              fifo_almost_full,
    output logic                              fifo_wr_en,
    output logic [DATA_WIDTH*OUT_CHANNEL-1:0] o_data,
    output logic                              o_frame_done
);
    localparam int GROUPS      = OUT_CHANNEL / PE_CHANNELS;
    localparam int PIXEL_WIDTH = DATA_WIDTH * OUT_CHANNEL;
    localparam int BEAT_WIDTH  = DATA_WIDTH * PE_CHANNELS;
    localparam int GRP_W       = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int COL_W       = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam int ROW_W       = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_HEIGHT - 1);

    typedef enum logic {RUN, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [GRP_W-1:0]        grp_reg, grp_next;
    logic [COL_W-1:0]        col_reg, col_next;
    logic [ROW_W-1:0]        row_reg, row_next;
    logic                    full_reg, full_next;
    logic [PIXEL_WIDTH-1:0]  out_q_reg;
    logic [PIXEL_WIDTH-1:0]  asm_word;
    logic [BEAT_WIDTH-1:0]   beat;
    logic                    last_grp;
    logic                    drain;
    logic                    accept;
    logic                    complete;

    genvar gi;
    generate
        for (gi = 0; gi < PE_CHANNELS; gi++) begin : g_clamp
            logic [DATA_WIDTH-1:0] ch;
            assign ch = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
`ifdef OUTPUT_RELU_EN
            assign beat[gi*DATA_WIDTH +: DATA_WIDTH] = ch[DATA_WIDTH-1] ? '0 : ch;
`else
            assign beat[gi*DATA_WIDTH +: DATA_WIDTH] = ch;
`endif
        end

        // The final slot is never stored: it is merged straight from the beat into out_q.
        for (gi = 0; gi < GROUPS; gi++) begin : g_slot
            if (gi == GROUPS - 1) begin : g_last
                assign asm_word[gi*BEAT_WIDTH +: BEAT_WIDTH] = beat;
            end else begin : g_store
                logic [BEAT_WIDTH-1:0] slot_reg;
                always_ff @(posedge clk) begin
                    if (accept && grp_reg == GRP_W'(gi)) begin
                        slot_reg <= beat;
                    end
                end
                assign asm_word[gi*BEAT_WIDTH +: BEAT_WIDTH] = slot_reg;
            end
        end
    endgenerate

    assign last_grp     = (grp_reg == LAST_GRP);
    assign drain        = full_reg && !fifo_almost_full && rst_n;
    assign o_ready      = !(last_grp && full_reg && !drain);
    assign accept       = i_valid && o_ready;
    assign complete     = accept && last_grp;
    assign fifo_wr_en   = drain;
    assign o_data       = out_q_reg;
    assign o_frame_done = (state_reg == DONE);

    always_comb begin
        grp_next  = grp_reg;
        full_next = full_reg;
        if (accept) begin
            grp_next = last_grp ? '0 : grp_reg + GRP_W'(1);
        end
        if (complete) begin
            full_next = 1'b1;
        end else if (drain) begin
            full_next = 1'b0;
        end
    end

    // Raster FSM: DONE is a single-cycle marker; counting continues in either state.
    always_comb begin
        state_next = RUN;
        col_next   = col_reg;
        row_next   = row_reg;
        if (drain) begin
            if (col_reg == LAST_COL) begin
                col_next = '0;
                if (row_reg == LAST_ROW) begin
                    row_next   = '0;
                    state_next = DONE;
                end else begin
                    row_next = row_reg + ROW_W'(1);
                end
            end else begin
                col_next = col_reg + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= RUN;
            grp_reg   <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
            full_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            grp_reg   <= grp_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            full_reg  <= full_next;
        end
    end

    always_ff @(posedge clk) begin
        if (complete) begin
            out_q_reg <= asm_word;
        end
    end
endmodule

// File: tb/tb_output_pixel_writer.sv
// Bench for output_pixel_writer: a 4-group instance (4x2 frame) and a single-group instance,
// checked against a cycle model with a scoreboard of expected pixel words.
module tb_output_pixel_writer;
    localparam int G = 4;
    localparam int W = 4;
    localparam int H = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  i_data;
    logic         i_valid;
    logic         o_ready;
    logic         fifo_almost_full;
    logic         fifo_wr_en;
    logic [127:0] o_data;
    logic         o_frame_done;

    logic [31:0]  g1_data;
    logic         g1_valid;
    logic         g1_ready;
    logic         g1_af;
    logic         g1_wr;
    logic [31:0]  g1_odata;
    logic         g1_done;

    always #5 clk = ~clk;

    output_pixel_writer #(.DATA_WIDTH(8), .OUT_CHANNEL(16), .PE_CHANNELS(4),
                          .OUT_WIDTH(W), .OUT_HEIGHT(H)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .fifo_almost_full(fifo_almost_full), .fifo_wr_en(fifo_wr_en), .o_data(o_data),
        .o_frame_done(o_frame_done));

    output_pixel_writer #(.DATA_WIDTH(8), .OUT_CHANNEL(4), .PE_CHANNELS(4),
                          .OUT_WIDTH(W), .OUT_HEIGHT(H)) u_dut_g1 (
        .clk(clk), .rst_n(rst_n), .i_data(g1_data), .i_valid(g1_valid), .o_ready(g1_ready),
        .fifo_almost_full(g1_af), .fifo_wr_en(g1_wr), .o_data(g1_odata),
        .o_frame_done(g1_done));

    typedef struct {
        bit           v;
        logic [31:0]  d;
        bit           af;
        bit           e_ready;
        bit           e_wr;
        logic [127:0] e_data;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [127:0] sb[$];
    logic [31:0]  sb1[$];
    int           m_grp = 0;
    bit           m_full = 0;
    bit           m_done = 0;
    int           m_col = 0;
    int           m_row = 0;
    logic [127:0] m_word = '0;

    bit           obs_ready;
    bit           obs_wr;
    logic [127:0] obs_data;
    logic [127:0] last_wr;
    int           n_wr = 0;
    int           n_done = 0;

    function automatic logic [31:0] relu(input logic [31:0] b);
        logic [31:0] r;
        r = b;
`ifdef OUTPUT_RELU_EN
        for (int k = 0; k < 4; k++) begin
            if (b[k*8+7]) r[k*8 +: 8] = 8'h00;
        end
`endif
        return r;
    endfunction

    task automatic check_bit(input string name, input bit act, input bit exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle on the 4-group instance: drive, compare against the model, advance the model.
    task automatic step(input bit rst, input bit v, input logic [31:0] d, input bit af);
        bit e_drain;
        bit e_ready;
        @(negedge clk);
        rst_n = rst;
        i_valid = v;
        i_data = d;
        fifo_almost_full = af;
        #1;
        e_drain = rst && m_full && !af;
        e_ready = !(m_grp == G - 1 && m_full && !e_drain);
        check_bit("o_ready", o_ready, e_ready);
        check_bit("fifo_wr_en", fifo_wr_en, e_drain);
        check_bit("o_frame_done", o_frame_done, m_done);
        obs_ready = o_ready;
        obs_wr = fifo_wr_en;
        obs_data = o_data;
        if (fifo_wr_en) begin
            n_wr++;
            last_wr = o_data;
        end
        if (o_frame_done) n_done++;
        if (e_drain) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: write expected but no word queued at %0t", $time);
            end else begin
                check_word("o_data", o_data, sb.pop_front());
            end
        end
        if (!rst) begin
            m_grp = 0; m_full = 0; m_done = 0; m_col = 0; m_row = 0;
            sb.delete();
        end else begin
            m_done = e_drain && m_col == W - 1 && m_row == H - 1;
            if (e_drain) begin
                m_full = 0;
                if (m_col == W - 1) begin
                    m_col = 0;
                    m_row = (m_row == H - 1) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
            if (v && e_ready) begin
                m_word[m_grp*32 +: 32] = relu(d);
                if (m_grp == G - 1) begin
                    sb.push_back(m_word);
                    m_full = 1;
                    m_grp = 0;
                end else begin
                    m_grp++;
                end
            end
        end
    endtask

    vec_t tbl[17];
    localparam logic [127:0] P1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] PA = 128'h10101013_10101012_10101011_10101010;
    localparam logic [127:0] PB = 128'h20202023_20202022_20202021_20202020;

    initial begin
        int wr0;
        int done0;
        int acc1;
        int wr1;
        bit g_full;
        bit e_drain;
        bit e_ready;
        logic [31:0] exp_slot;

        // Basic packing, then two pixels under backpressure with a stalled 8th beat.
        tbl[0]  = '{1'b1, 32'h03020100, 1'b0, 1'b1, 1'b0, 128'h0};
        tbl[1]  = '{1'b1, 32'h07060504, 1'b0, 1'b1, 1'b0, 128'h0};
        tbl[2]  = '{1'b1, 32'h0B0A0908, 1'b0, 1'b1, 1'b0, 128'h0};
        tbl[3]  = '{1'b1, 32'h0F0E0D0C, 1'b0, 1'b1, 1'b0, 128'h0};
        tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, P1};
        tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 128'h0};
        tbl[6]  = '{1'b1, 32'h10101010, 1'b1, 1'b1, 1'b0, 128'h0};
        tbl[7]  = '{1'b1, 32'h10101011, 1'b1, 1'b1, 1'b0, 128'h0};
        tbl[8]  = '{1'b1, 32'h10101012, 1'b1, 1'b1, 1'b0, 128'h0};
        tbl[9]  = '{1'b1, 32'h10101013, 1'b1, 1'b1, 1'b0, 128'h0};
        tbl[10] = '{1'b1, 32'h20202020, 1'b1, 1'b1, 1'b0, 128'h0};
        tbl[11] = '{1'b1, 32'h20202021, 1'b1, 1'b1, 1'b0, 128'h0};
        tbl[12] = '{1'b1, 32'h20202022, 1'b1, 1'b1, 1'b0, 128'h0};
        tbl[13] = '{1'b1, 32'h20202023, 1'b1, 1'b0, 1'b0, 128'h0};
        tbl[14] = '{1'b1, 32'h20202023, 1'b0, 1'b1, 1'b1, PA};
        tbl[15] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, PB};
        tbl[16] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 128'h0};

        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; fifo_almost_full = 1'b0;
        g1_valid = 1'b0; g1_data = '0; g1_af = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            step(1'b1, tbl[i].v, tbl[i].d, tbl[i].af);
            $display("vec %0d: v=%0d d=%h af=%0d ready=%0d wr=%0d", i, tbl[i].v, tbl[i].d,
                     tbl[i].af, obs_ready, obs_wr);
            check_bit($sformatf("tbl%0d_ready", i), obs_ready, tbl[i].e_ready);
            check_bit($sformatf("tbl%0d_wr", i), obs_wr, tbl[i].e_wr);
            if (tbl[i].e_wr) check_word($sformatf("tbl%0d_data", i), obs_data, tbl[i].e_data);
        end

        // Frame end: 16 pixels from reset spans two 4x2 frames, so two done pulses.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        wr0 = n_wr;
        done0 = n_done;
        for (int p = 0; p < 9; p++) begin
            for (int g = 0; g < G; g++) step(1'b1, 1'b1, {8'(p), 8'(g), 16'h1122}, 1'b0);
        end
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        $display("frame: writes=%0d done_pulses=%0d", n_wr - wr0, n_done - done0);
        check_word("frame_writes_9", 128'(n_wr - wr0), 128'd9);
        check_word("frame_done_count_1", 128'(n_done - done0), 128'd1);
        for (int p = 9; p < 16; p++) begin
            for (int g = 0; g < G; g++) step(1'b1, 1'b1, {8'(p), 8'(g), 16'h3344}, 1'b0);
        end
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        $display("frame: writes=%0d done_pulses=%0d", n_wr - wr0, n_done - done0);
        check_word("frame_done_count_2", 128'(n_done - done0), 128'd2);

        // Reset mid-pixel discards the two earlier beats.
        step(1'b1, 1'b1, 32'h55555555, 1'b0);
        step(1'b1, 1'b1, 32'h66666666, 1'b0);
        for (int r = 0; r < 2; r++) begin
            step(1'b0, 1'b1, 32'h77777777, 1'b0);
            $display("reset cycle %0d: ready=%0d wr=%0d", r, obs_ready, obs_wr);
            check_bit("rst_ready", obs_ready, 1'b1);
            check_bit("rst_wr", obs_wr, 1'b0);
        end
        wr0 = n_wr;
        for (int g = 0; g < G; g++) step(1'b1, 1'b1, {4{8'(g + 1)}}, 1'b0);
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);
        $display("reset: writes=%0d word=%h", n_wr - wr0, last_wr);
        check_word("rst_writes", 128'(n_wr - wr0), 128'd1);
        check_word("rst_word", last_wr, 128'h04040404_03030303_02020202_01010101);

        // Channel clamp on the first slot.
`ifdef OUTPUT_RELU_EN
        exp_slot = 32'h00007F01;
`else
        exp_slot = 32'h80FF7F01;
`endif
        step(1'b1, 1'b1, 32'h80FF7F01, 1'b0);
        for (int g = 1; g < G; g++) step(1'b1, 1'b1, 32'h0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);
        $display("relu: slot0=%h", last_wr[31:0]);
        check_word("relu_slot", 128'(last_wr[31:0]), 128'(exp_slot));

        // Single-group instance with almost_full toggling each cycle.
        g_full = 0;
        acc1 = 0;
        wr1 = 0;
        for (int c = 0; c < 42; c++) begin
            @(negedge clk);
            g1_valid = (c < 40);
            g1_data = $urandom;
            g1_af = (c < 40) ? c[0] : 1'b0;
            #1;
            e_drain = g_full && !g1_af;
            e_ready = !g_full || e_drain;
            $display("g1 cycle %0d: v=%0d af=%0d ready=%0d wr=%0d", c, g1_valid, g1_af, g1_ready, g1_wr);
            check_bit("g1_ready", g1_ready, e_ready);
            check_bit("g1_wr", g1_wr, e_drain);
            if (g1_wr) wr1++;
            if (e_drain) begin
                if (sb1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL g1_scoreboard: write expected but no word queued at %0t", $time);
                end else begin
                    check_word("g1_data", 128'(g1_odata), 128'(sb1.pop_front()));
                end
                g_full = 0;
            end
            if (g1_valid && e_ready) begin
                sb1.push_back(relu(g1_data));
                g_full = 1;
                acc1++;
            end
        end
        $display("g1: accepted=%0d written=%0d", acc1, wr1);
        check_word("g1_count", 128'(wr1), 128'(acc1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
